// File: rtl/bitrev_reorder.sv
// -----------------------------------------------------------------------------
// bitrev_reorder
//   Output reorder stage at the tail of the SDF FFT pipeline. The SDF stages
//   emit each frame in bit-reversed bin order. This block captures a complete
//   N-sample frame into one bank of a ping-pong RAM. It then replays that bank
//   in natural order 0..N-1 while the next frame fills the other bank.
//
//   Optional feature macro: BITREV_SOP_EN
//     Defining it adds output port out_sop. The port is high for one cycle
//     with bin 0 of every replayed frame.
//
//   Stream semantics, input and output alike (no backpressure):
//     enable_* high means the data on the re/im bus in the same cycle is a
//     valid sample. There is one sample per cycle. The consumer must accept
//     every sample that is presented.
// -----------------------------------------------------------------------------
module bitrev_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
`ifdef BITREV_SOP_EN
  ,
  output logic             out_sop
`endif
);

  localparam int              LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  // Read-side FSM. It is either idle or draining one bank.
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Reverse the bit order of a LOGN-bit index.
  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) begin
      r[b] = v[LOGN-1-b];
    end
    return r;
  endfunction

  // Ping-pong storage. Each word is {re, im}.
  logic [2*WIDTH-1:0] bank_a [N];
  logic [2*WIDTH-1:0] bank_b [N];

  // Write-side state
  logic [LOGN-1:0]    wr_cnt;
  logic               wsel;        // bank currently being filled
  logic               rsel;        // bank holding the newest complete frame
  logic               read_start;  // one-cycle pulse after a frame completes
  logic [1:0]         bank_full;   // per-bank "complete frame waiting" flag

  // Read-side state
  state_t             state;
  logic [LOGN-1:0]    rd_cnt;
  logic               drain_bank;  // bank being drained (latched at drain start)

  // Combinational helpers
  logic               frame_done;
  logic               drain_done;
  logic               start_ok;
  logic [LOGN-1:0]    wr_addr;
  logic [2*WIDTH-1:0] wr_word;
  logic [2*WIDTH-1:0] rd_word;

  assign frame_done = enable_in && (wr_cnt == LAST);
  assign drain_done = (state == DRAIN) && (rd_cnt == LAST);
  // A drain may only start on a bank that actually holds a complete frame.
  assign start_ok   = read_start && bank_full[rsel];
  assign wr_addr    = bitrev(wr_cnt);
  assign wr_word    = {in_re, in_im};
  // drain_bank is latched when a drain starts. rsel can move to the next
  // bank one cycle before the current drain reads its last word.
  assign rd_word    = drain_bank ? bank_b[rd_cnt] : bank_a[rd_cnt];

  // Write-side sequencing: count samples, swap banks on frame completion,
  // and drop a partial frame when enable_in falls early.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt     <= '0;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      read_start <= 1'b0;
    end else begin
      read_start <= 1'b0;
      if (enable_in) begin
        if (wr_cnt == LAST) begin
          wr_cnt     <= '0;
          rsel       <= wsel;
          wsel       <= ~wsel;
          read_start <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + LOGN'(1);
        end
      end else begin
        // Either already idle or aborting a partial frame. No swap happens.
        wr_cnt <= '0;
      end
    end
  end

  // RAM write port. Samples go to their natural-order address.
  // Contents are never reset. A sample presented together with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && enable_in) begin
      if (wsel) begin
        bank_b[wr_addr] <= wr_word;
      end else begin
        bank_a[wr_addr] <= wr_word;
      end
    end
  end

  // Bank occupancy. A completed frame sets its flag, and a finished drain
  // clears its flag. The two never target the same bank on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= '0;
    end else begin
      if (drain_done) begin
        bank_full[drain_bank] <= 1'b0;
      end
      if (frame_done) begin
        bank_full[wsel] <= 1'b1;
      end
    end
  end

  // Read FSM with registered outputs. It drains one bank in natural order.
  // If the next frame is already complete, it restarts without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      drain_bank <= 1'b0;
      enable_out <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      enable_out <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= DRAIN;
            rd_cnt     <= '0;
            drain_bank <= rsel;
          end
        end
        DRAIN: begin
          enable_out <= 1'b1;
          out_re     <= rd_word[2*WIDTH-1:WIDTH];
          out_im     <= rd_word[WIDTH-1:0];
          if (rd_cnt == LAST) begin
            rd_cnt <= '0;
            if (start_ok) begin
              drain_bank <= rsel;
            end else begin
              state <= IDLE;
            end
          end else begin
            rd_cnt <= rd_cnt + LOGN'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BITREV_SOP_EN
  // Start-of-frame marker, aligned with the registered bin-0 output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sop <= 1'b0;
    end else begin
      out_sop <= (state == DRAIN) && (rd_cnt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_bitrev_reorder
//   Self-checking bench for bitrev_reorder with N=8 and WIDTH=8.
//   The drivers record every complete input frame in a reference model.
//   For each frame, the model pushes the natural-order output words and the
//   edge at which each word is due into a scoreboard queue.
//   A negedge monitor pops entries and compares them whenever enable_out is
//   high.
// -----------------------------------------------------------------------------
module tb_bitrev_reorder;

  localparam int N     = 8;
  localparam int LOGN  = 3;
  localparam int WIDTH = 8;
  localparam int W     = 2 * WIDTH + 1;  // {sop, re, im}

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable_in = 1'b0;
  logic [WIDTH-1:0] in_re = '0;
  logic [WIDTH-1:0] in_im = '0;
  logic             enable_out;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;
  logic             sop_obs;

  always #5 clk = ~clk;

  int edge_n = 0;  // number of posedges so far
  always @(posedge clk) edge_n <= edge_n + 1;

`ifdef BITREV_SOP_EN
  logic out_sop;
  assign sop_obs = out_sop;
`else
  assign sop_obs = 1'b0;
`endif

  bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_in  (enable_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .enable_out (enable_out),
    .out_re     (out_re),
    .out_im     (out_im)
`ifdef BITREV_SOP_EN
    ,
    .out_sop    (out_sop)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_edge_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         mon_on   = 1'b0;

  // Reference model: the samples of the frame in arrival order
  logic [WIDTH-1:0] fr_re [N];
  logic [WIDTH-1:0] fr_im [N];
  int               fr_cnt   = 0;
  int               fr_start = 0;

  function automatic int rev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < LOGN; b++) begin
      if (((v >> b) & 1) != 0) r = r | (1 << (LOGN - 1 - b));
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one sample. When it completes a frame, queue the natural-order
  // replay. Bin k is the sample that arrived at position rev(k), and it is due
  // N+1+k edges after the first sample of the frame.
  task automatic drive_sample(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
    if (fr_cnt == 0) fr_start = edge_n + 1;
    fr_re[fr_cnt] = re;
    fr_im[fr_cnt] = im;
    fr_cnt++;
    if (fr_cnt == N) begin
      for (int k = 0; k < N; k++) begin
        exp_q.push_back({(k == 0), fr_re[rev(k)], fr_im[rev(k)]});
        exp_edge_q.push_back(fr_start + N + 1 + k);
      end
      fr_cnt = 0;
    end
    enable_in = 1'b1;
    in_re     = re;
    in_im     = im;
    @(posedge clk);
    #1;
  endtask

  // Hold enable_in low for n cycles with junk on the data bus.
  // Any partial frame is lost.
  task automatic idle(input int n);
    enable_in = 1'b0;
    in_re     = WIDTH'($urandom);
    in_im     = WIDTH'($urandom);
    fr_cnt    = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle reset with a valid-looking sample that must be ignored.
  // Pending expectations are dropped at the reset edge.
  task automatic pulse_reset();
    rst       = 1'b1;
    enable_in = 1'b1;
    in_re     = 8'hAA;
    in_im     = 8'h55;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_edge_q.delete();
    fr_cnt    = 0;
    rst       = 1'b0;
    enable_in = 1'b0;
    check("rst_enable_out", int'(enable_out), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_out_im", int'(out_im), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      while (exp_edge_q.size() > 0 && exp_edge_q[0] < edge_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_output: expected word %h due at edge %0d not seen (now %0d)",
                 exp_q[0], exp_edge_q[0], edge_n);
        void'(exp_q.pop_front());
        void'(exp_edge_q.pop_front());
      end
      if (enable_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: re=%h im=%h at edge %0d, nothing expected",
                   out_re, out_im, edge_n);
        end else begin
          logic [W-1:0] e;
          int           t;
          e = exp_q.pop_front();
          t = exp_edge_q.pop_front();
          if (out_re !== e[2*WIDTH-1:WIDTH] || out_im !== e[WIDTH-1:0] || t != edge_n) begin
            n_fail++;
            $display("FAIL output_word: got re=%h im=%h at edge %0d, expected re=%h im=%h at edge %0d",
                     out_re, out_im, edge_n, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0], t);
          end
`ifdef BITREV_SOP_EN
          n_checks++;
          if (sop_obs !== e[W-1]) begin
            n_fail++;
            $display("FAIL out_sop: got %b expected %b at edge %0d", sop_obs, e[W-1], edge_n);
          end
`endif
        end
      end else begin
        n_checks++;
        if (out_re !== '0 || out_im !== '0 || sop_obs !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs: got re=%h im=%h sop=%b expected zeros at edge %0d",
                   out_re, out_im, sop_obs, edge_n);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_enable_out", int'(enable_out), 0);
    check("reset_out_re", int'(out_re), 0);
    check("reset_out_im", int'(out_im), 0);
    check("reset_out_sop", int'(sop_obs), 0);
    rst    = 1'b0;
    mon_on = 1'b1;
    idle(2);

    // Single frame: re = i, im = 8 - i
    for (int i = 0; i < N; i++) drive_sample(WIDTH'(i), WIDTH'(8 - i));
    idle(N + 4);

    // Three back-to-back frames: re = 16f + rev(i)
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) drive_sample(WIDTH'(16 * f + rev(i)), WIDTH'($urandom));
    end
    idle(N + 4);

    // Abort after 5 samples, then a full frame
    for (int i = 0; i < 5; i++) drive_sample(WIDTH'(8'h40 + i), WIDTH'(i));
    idle(2);
    for (int i = 0; i < N; i++) drive_sample(WIDTH'(rev(i)), WIDTH'(8'hF0 + i));
    idle(N + 4);

    // Reset on the 3rd output cycle, then a full frame with nominal latency
    for (int i = 0; i < N; i++) drive_sample(WIDTH'(8'h20 + i), WIDTH'(8'h30 + i));
    idle(3);
    pulse_reset();
    idle(1);
    for (int i = 0; i < N; i++) drive_sample(WIDTH'(8'h60 + i), WIDTH'(8'h70 + i));
    idle(N + 4);

    // Two frames with sign bit set, separated by 3 idle cycles
    for (int i = 0; i < N; i++) drive_sample(WIDTH'(8'h80 + i), WIDTH'(8'h87 - i));
    idle(3);
    for (int i = 0; i < N; i++) drive_sample(WIDTH'(8'h80 + i), WIDTH'(8'h87 - i));
    idle(N + 4);

    // Random frames, random aborts, random gaps (including zero)
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(3, 0) == 0) begin
        for (int i = 0; i < int'($urandom_range(N - 1, 1)); i++)
          drive_sample(WIDTH'($urandom), WIDTH'($urandom));
        idle($urandom_range(3, 1));
      end
      for (int i = 0; i < N; i++) drive_sample(WIDTH'($urandom), WIDTH'($urandom));
      if ($urandom_range(2, 0) != 0) idle($urandom_range(3, 1));
    end
    idle(1);

    // Drain with a bounded wait
    for (int c = 0; c < 4 * N && exp_q.size() > 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_empty", exp_q.size(), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
